// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI frame loader: FSM state encoding,
// default header byte and the byte width used to split words.
package spi_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_DIN,
        ST_LOAD_WIN,
        ST_LOAD_BIAS,
        ST_COMMIT
    } state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         BYTE_W       = 8;

endpackage

// File: rtl/spi_word_assembler.sv
// Collects DATA_W/8 bytes, MSB byte first, into one word. word_o is valid
// together with word_done_o in the cycle the final byte is presented.
module spi_word_assembler
    import spi_loader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_done_o
);
    localparam int NB = DATA_W / BYTE_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0] cnt_q;

    assign word_done_o = en_i && (cnt_q == CW'(NB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= word_done_o ? '0 : cnt_q + 1'b1;
        end
    end

    if (NB == 1) begin : g_single
        assign word_o = byte_i;
    end else begin : g_multi
        // Only the earlier bytes are held; the final byte joins combinationally.
        logic [DATA_W-9:0] shift_q;

        assign word_o = {shift_q, byte_i};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shift_q <= '0;
            end else if (en_i) begin
                shift_q <= word_o[DATA_W-9:0];
            end
        end
    end

endmodule

// File: rtl/spi_frame_loader.sv
// Framed SPI byte loader: SYNC header, N_IN din words, N_IN win words, one
// bias word, staged and committed atomically to the registered outputs.
module spi_frame_loader
    import spi_loader_pkg::*;
#(
    parameter int         N_IN    = 4,
    parameter int         DATA_W  = 8,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT,
    parameter int         TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_done,
    input  logic [7:0]             spi_dout,
    output logic [N_IN*DATA_W-1:0] din,
    output logic [N_IN*DATA_W-1:0] win,
    output logic [DATA_W-1:0]      bias,
    output logic                   frame_valid,
    output logic                   busy,
    output logic                   err_sync,
    output logic                   err_timeout
);
    localparam int WW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int TW = $clog2(TIMEOUT);

    state_e                      state_q;
    logic [WW-1:0]               widx_q;
    logic [TW-1:0]               tmo_q;
    logic [N_IN-1:0][DATA_W-1:0] stg_din_q, stg_win_q;
    logic [N_IN-1:0][DATA_W-1:0] din_q, win_q;
    logic [DATA_W-1:0]           bias_q;
    logic                        frame_valid_q, busy_q, err_sync_q, err_timeout_q;

    logic              in_load, hdr_ok, byte_acc, last_word, word_done;
    logic [DATA_W-1:0] word;

    assign in_load   = (state_q == ST_LOAD_DIN) || (state_q == ST_LOAD_WIN) ||
                       (state_q == ST_LOAD_BIAS);
    assign hdr_ok    = !in_load && spi_done && (spi_dout == SYNC);
    assign byte_acc  = in_load && spi_done;
    assign last_word = (widx_q == WW'(N_IN - 1));

    spi_word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (hdr_ok),
        .en_i        (byte_acc),
        .byte_i      (spi_dout),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            widx_q        <= '0;
            tmo_q         <= '0;
            stg_din_q     <= '0;
            stg_win_q     <= '0;
            din_q         <= '0;
            win_q         <= '0;
            bias_q        <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_sync_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            err_sync_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                // COMMIT shares the header check so a back-to-back SYNC is not lost.
                ST_IDLE, ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    tmo_q   <= '0;
                    if (spi_done) begin
                        if (hdr_ok) begin
                            state_q <= ST_LOAD_DIN;
                            widx_q  <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            err_sync_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (spi_done) begin
                        tmo_q <= '0;
                        if (word_done) begin
                            widx_q <= last_word ? '0 : widx_q + 1'b1;
                            case (state_q)
                                ST_LOAD_DIN: begin
                                    stg_din_q[widx_q] <= word;
                                    if (last_word) state_q <= ST_LOAD_WIN;
                                end
                                ST_LOAD_WIN: begin
                                    stg_win_q[widx_q] <= word;
                                    if (last_word) state_q <= ST_LOAD_BIAS;
                                end
                                default: begin
                                    // Outputs load on the edge entering COMMIT, so they
                                    // and frame_valid are visible during COMMIT itself.
                                    state_q       <= ST_COMMIT;
                                    din_q         <= stg_din_q;
                                    win_q         <= stg_win_q;
                                    bias_q        <= word;
                                    frame_valid_q <= 1'b1;
                                end
                            endcase
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        tmo_q         <= '0;
                        err_timeout_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign din         = din_q;
    assign win         = win_q;
    assign bias        = bias_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
    assign err_sync    = err_sync_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboard bench: the driver feeds a byte-level frame parser that queues the
// expected pulses; the negedge monitor pops and compares as the DUT reports.
module tb_spi_frame_loader;
    localparam int         N_IN    = 2;
    localparam int         DATA_W  = 16;
    localparam int         TIMEOUT = 16;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         BPW     = DATA_W / 8;
    localparam int         NW      = 2 * N_IN + 1;
    localparam int K_FRAME = 0, K_SYNC = 1, K_TMO = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   spi_done;
    logic [7:0]             spi_dout;
    logic [N_IN*DATA_W-1:0] din, win;
    logic [DATA_W-1:0]      bias;
    logic                   frame_valid, busy, err_sync, err_timeout;

    typedef struct {
        int                     kind;
        int                     cyc;
        logic                   bsy;
        logic [N_IN*DATA_W-1:0] d;
        logic [N_IN*DATA_W-1:0] w;
        logic [DATA_W-1:0]      b;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;
    bit   stim_done = 0;

    bit         in_frame = 0;
    int         last_acc = 0;
    logic [7:0] fb[$];

    logic [N_IN*DATA_W-1:0] held_d = '0, held_w = '0;
    logic [DATA_W-1:0]      held_b = '0;

    logic [7:0] vec[11] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
                            8'hBC, 8'hDE, 8'hF0, 8'hCA, 8'hFE};

    spi_frame_loader #(.N_IN(N_IN), .DATA_W(DATA_W), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_done    (spi_done),
        .spi_dout    (spi_dout),
        .din         (din),
        .win         (win),
        .bias        (bias),
        .frame_valid (frame_valid),
        .busy        (busy),
        .err_sync    (err_sync),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference parser: one call per accepted byte, e = clock edge it lands on.
    task automatic model_byte(input logic [7:0] b, input int e);
        exp_t x;
        x.cyc = e; x.d = '0; x.w = '0; x.b = '0;
        if (!in_frame) begin
            if (b == SYNC) begin
                in_frame = 1; fb.delete(); last_acc = e;
            end else begin
                x.kind = K_SYNC; x.bsy = 1'b0; q.push_back(x);
            end
        end else begin
            fb.push_back(b);
            last_acc = e;
            if (fb.size() == NW * BPW) begin
                x.kind = K_FRAME; x.bsy = 1'b1;
                for (int wi = 0; wi < NW; wi++) begin
                    logic [DATA_W-1:0] v;
                    v = '0;
                    for (int k = 0; k < BPW; k++) v = v * 256 + DATA_W'(fb[wi*BPW+k]);
                    if (wi < N_IN)          x.d[wi*DATA_W +: DATA_W] = v;
                    else if (wi < 2 * N_IN) x.w[(wi-N_IN)*DATA_W +: DATA_W] = v;
                    else                    x.b = v;
                end
                q.push_back(x);
                in_frame = 0;
            end
        end
    endtask

    task automatic idle_edge();
        exp_t x;
        if (in_frame && cyc + 1 == last_acc + TIMEOUT) begin
            x.kind = K_TMO; x.cyc = cyc + 1; x.bsy = 1'b0;
            x.d = '0; x.w = '0; x.b = '0;
            q.push_back(x);
            in_frame = 0;
        end
        @(posedge clk); #1;
    endtask

    // gap = clock edges since the previous strobe (1 = consecutive cycles)
    task automatic send(input logic [7:0] b, input int gap);
        for (int i = 1; i < gap; i++) idle_edge();
        model_byte(b, cyc + 1);
        spi_done = 1'b1; spi_dout = b;
        @(posedge clk); #1;
        spi_done = 1'b0; spi_dout = 8'($urandom_range(0, 255));
    endtask

    task automatic rand_frame(input int gmax);
        send(SYNC, $urandom_range(1, gmax));
        for (int i = 0; i < NW * BPW; i++) send(8'($urandom_range(0, 255)), $urandom_range(1, gmax));
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    initial begin
        rst_n = 1'b0; spi_done = 1'b0; spi_dout = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_edge();
        foreach (vec[i]) send(vec[i], 1);
        send(8'h3C, 3);
        foreach (vec[i]) send(vec[i] ^ ((i == 0) ? 8'h00 : 8'h5A), (i == 0) ? 2 : 1);
        // stall after 5 bytes, then a clean frame
        send(SYNC, 2);
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), 1);
        send(SYNC, 21);
        for (int i = 0; i < NW * BPW; i++) send(8'($urandom_range(0, 255)), 1);
        // gap of exactly TIMEOUT survives, TIMEOUT+1 aborts
        send(SYNC, 3);
        for (int i = 0; i < NW * BPW; i++) send(8'($urandom_range(0, 255)), (i == 3) ? TIMEOUT : 1);
        send(SYNC, 2);
        send(8'h11, 1); send(8'h22, 1);
        send(8'h00, TIMEOUT + 1);
        // back-to-back: next SYNC arrives in the COMMIT cycle
        rand_frame(1);
        rand_frame(1);
        send(8'h77, 1);
        // reset mid-frame
        rand_frame(2);
        send(SYNC, 1); send(8'h01, 1); send(8'h02, 1); send(8'h03, 1);
        rst_n = 1'b0; in_frame = 0;
        repeat (2) idle_edge();
        rst_n = 1'b1;
        idle_edge();
        rand_frame(3);
        repeat (300) begin
            int r, g;
            logic [7:0] b;
            r = $urandom_range(0, 19);
            g = (r < 17) ? 1 + (r % 3) : $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
            b = (!in_frame && $urandom_range(0, 9) < 8) ? SYNC : 8'($urandom_range(0, 255));
            send(b, g);
        end
        repeat (TIMEOUT + 4) idle_edge();
        stim_done = 1;
    end

    always @(negedge clk) begin
        exp_t x;
        int   nev;
        if (!rst_n) begin
            held_d = '0; held_w = '0; held_b = '0;
            chk("reset_din", din, '0);
            chk("reset_win", win, '0);
            chk("reset_bias", bias, '0);
            chk("reset_flags", {frame_valid, busy, err_sync, err_timeout}, '0);
        end else begin
            nev = int'(frame_valid) + int'(err_sync) + int'(err_timeout);
            if (nev > 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {frame_valid, err_sync, err_timeout}, '0);
                end else begin
                    x = q.pop_front();
                    chk("event_kind", {frame_valid, err_sync, err_timeout},
                        (x.kind == K_FRAME) ? 3'b100 : (x.kind == K_SYNC) ? 3'b010 : 3'b001);
                    chk("event_cycle", cyc, x.cyc);
                    chk("event_busy", busy, x.bsy);
                    if (x.kind == K_FRAME) begin
                        chk("frame_din", din, x.d);
                        chk("frame_win", win, x.w);
                        chk("frame_bias", bias, x.b);
                        held_d = x.d; held_w = x.w; held_b = x.b;
                    end else begin
                        chk("held_din", din, held_d);
                        chk("held_win", win, held_w);
                        chk("held_bias", bias, held_b);
                    end
                end
            end
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                n_cmp++; n_err++;
                $display("FAIL missed_event: kind %0d due at cycle %0d, not seen by cycle %0d",
                         q[0].kind, q[0].cyc, cyc);
                void'(q.pop_front());
            end
        end
        if (stim_done) begin
            chk("final_din", din, held_d);
            chk("queue_empty", q.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

endmodule

// File: doc/spi_frame_loader.md
# spi_frame_loader

Parametrised successor to the three-register SPI byte distributor. It assembles a framed SPI byte stream into N_IN input words, N_IN weight words and one bias word of DATA_W bits each, held in a staging buffer. The buffer commits atomically to the accelerator-facing output registers only when a complete, well-formed frame has arrived. The block sits between the SPI slave (byte-done strobe plus byte) and the time-based MAC array. It adds a sync header, multi-byte words, an inter-byte timeout and tear-free double buffering.

## Interface
- N_IN, 4: number of input/weight channel pairs (≥1)
- DATA_W, 8: word width in bits; multiple of 8, 8..32
- SYNC, 8'hA5: required frame header byte
- TIMEOUT, 1024: max clk cycles between accepted bytes inside a frame (≥2)

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- spi_done  input  1  one-cycle strobe, clk-synchronous; spi_dout valid in the same cycle
- spi_dout  input  8  received SPI byte
- din  output  N_IN*DATA_W  committed input words; channel i at [i*DATA_W +: DATA_W]
- win  output  N_IN*DATA_W  committed weight words, same packing
- bias  output  DATA_W  committed bias word
- frame_valid  output  1  one-cycle pulse: outputs updated this cycle
- busy  output  1  high while a frame is in progress (any state but IDLE)
- err_sync  output  1  one-cycle pulse: header byte ≠ SYNC
- err_timeout  output  1  one-cycle pulse: frame aborted by timeout

## Operation
- Frame layout: SYNC, then N_IN din words, then N_IN win words, then 1 bias word. Each word is DATA_W/8 bytes, MSB byte first. Total bytes per frame = 1 + (2*N_IN+1)*DATA_W/8.
- States: IDLE, LOAD_DIN, LOAD_WIN, LOAD_BIAS, COMMIT.
- IDLE: when spi_done is high:
  - spi_dout == SYNC: go to LOAD_DIN, clear the byte and word counters.
  - otherwise: pulse err_sync and stay in IDLE.
- LOAD_*: each spi_done shifts spi_dout into the staging word indexed by the word counter, then advances the byte counter.
  - After the last byte of a word, the word counter advances.
  - After word N_IN-1 of din or win, move to the next section with the word counter cleared.
  - After the last bias byte, go to COMMIT.
- COMMIT (exactly 1 cycle):
  - Staging buffer copies to din/win/bias and frame_valid pulses.
  - Return to IDLE.
  - A spi_done in this cycle is handled with IDLE rules (header check), so back-to-back frames lose no bytes.
- Staging contents are never visible on the outputs except through COMMIT. Aborted frames leave the outputs unchanged.
- Timeout counter:
  - Clears on every accepted spi_done and in IDLE.
  - Increments each cycle in LOAD_* states.
  - On reaching TIMEOUT-1 with no spi_done that cycle: pulse err_timeout, go to IDLE.
- Simultaneous spi_done and timeout expiry: the byte is accepted and no timeout occurs.
- Width rules: counters sized with $clog2; a byte counter wrap at DATA_W/8 is the word-advance condition. No arithmetic overflow paths exist.

## Timing
- Reset (rst_n low, asynchronous) sets: state IDLE; din, win, bias, staging buffer and all counters to 0; frame_valid, busy, err_sync and err_timeout to 0.
- Reset asserted mid-frame discards the frame. No commit occurs after release.
- Latency: last bias byte strobe at cycle T → outputs and frame_valid change at cycle T+1 (registered, in COMMIT).
- busy rises the cycle after the SYNC byte is accepted and falls on the cycle after COMMIT.
- err_* pulses are registered: asserted the cycle after the causing event.
- All outputs are registered; there is no combinational path from spi_* to any output.

## Structure
- Shared package spi_loader_pkg: state enum, default SYNC constant, byte-width localparam.
- Sub-module spi_word_assembler: byte shift register plus byte counter producing a DATA_W word and a word_done strobe. It is instantiated once; the FSM steers word_done into the staging array.
- Target size about 200–300 RTL lines.

## Test plan
- Defaults; send A5 then din 01..04, win 11..14, bias 7F → din=32'h04030201, win=32'h14131211, bias=8'h7F; one frame_valid, one cycle after the bias byte.
- DATA_W=16, N_IN=2; send A5 12 34 56 78 9A BC DE F0 CA FE → din={16'h5678,16'h1234}, win={16'hDEF0,16'h9ABC}, bias=16'hCAFE.
- Send 3C before A5 → err_sync pulses once; the following valid frame loads normally.
- TIMEOUT=16; stall 20 cycles after 5 bytes → err_timeout at cycle 16 after the last byte; outputs keep the previous frame; the next full frame commits.
- Back-to-back frames with the next A5 strobed in the COMMIT cycle → both frames commit; two frame_valid pulses.
- Assert rst_n low mid-frame → all outputs 0 immediately; no frame_valid after release until a new complete frame arrives.
